core_scheduler: RTL and testbench

Sequences the internal instruction bus between the SPI instruction handler and NUM_CORES core interface instances.
- Decodes the address into a core index and a local offset.
- Forwards WRITE/READ to exactly one core.
- Runs a core (start pulse, wait for done, timeout) and returns results and a status byte to the handler.
- Sits between instruction_handler and the core_interface instances, replacing direct bus fan-out.

---
 rtl/titan_bus_pkg.sv | 27 ++
 rtl/cycle_timeout.sv | 26 ++
 rtl/core_scheduler.sv | 161 ++++++++++++++++
 tb/tb_core_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/titan_bus_pkg.sv
// Shared definitions for the internal instruction bus: opcodes, outcome codes,
// scheduler FSM states and the default per-core address window.
package titan_bus_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_RUN    = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h04;

    localparam int unsigned DEFAULT_CORE_SPAN_LOG2 = 4;

    typedef enum logic [3:0] {
        OUT_OK         = 4'd0,
        OUT_TIMEOUT    = 4'd1,
        OUT_ERR_ADDR   = 4'd2,
        OUT_ERR_OPCODE = 4'd3
    } outcome_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FORWARD,
        ST_RUN_WAIT,
        ST_CAPTURE
    } state_t;

endpackage

// File: rtl/cycle_timeout.sv
// Wait-cycle counter with synchronous clear/enable; tc_o flags the last
// permitted wait cycle (count == TIMEOUT_CYCLES-1).
module cycle_timeout #(
    parameter int unsigned TW             = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + TW'(1);
        end
    end

    assign tc_o = (count_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/core_scheduler.sv
// Routes instruction-bus transactions from the SPI instruction handler to one
// of NUM_CORES core interfaces, runs cores with a timeout and reports status.
import titan_bus_pkg::*;

module core_scheduler #(
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned CORE_SPAN_LOG2 = DEFAULT_CORE_SPAN_LOG2,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TW             = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              instruction_i,
    input  logic [23:0]             address_i,
    input  logic [31:0]             value_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    output logic                    busy_o,
    output logic [NUM_CORES-1:0]    core_sel_o,
    output logic [7:0]              core_instruction_o,
    output logic [23:0]             core_address_o,
    output logic [31:0]             core_value_o,
    output logic [NUM_CORES-1:0]    core_start_o,
    input  logic [NUM_CORES-1:0]    core_done_i,
    input  logic [32*NUM_CORES-1:0] core_result_i,
    output logic [31:0]             result_o,
    output logic [7:0]              status_o
);

    localparam int unsigned IW = 24 - CORE_SPAN_LOG2;

    state_t         state;
    outcome_t       outcome;
    logic           overrun;
    logic [2:0]     last_core;
    logic [2:0]     k_q;
    logic [7:0]     op_q;

    logic [IW-1:0]        addr_idx;
    logic                 in_range;
    logic [NUM_CORES-1:0] addr_onehot;
    logic [NUM_CORES-1:0] k_onehot;
    logic [31:0]          sel_result;
    logic                 done_sel;
    logic                 tc;

    // The full upper field is compared, so stray high address bits land out of range.
    assign addr_idx = address_i[23:CORE_SPAN_LOG2];
    assign in_range = (addr_idx < IW'(NUM_CORES));

    always_comb begin
        addr_onehot = '0;
        k_onehot    = '0;
        sel_result  = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (addr_idx == IW'(i)) addr_onehot[i] = 1'b1;
            if (k_q == 3'(i)) begin
                k_onehot[i] = 1'b1;
                sel_result  = core_result_i[32*i +: 32];
            end
        end
    end

    assign done_sel      = |(core_done_i & k_onehot);
    assign instr_ready_o = (state == ST_IDLE);
    assign busy_o        = ~instr_ready_o;
    assign status_o      = {last_core, overrun, outcome};

    cycle_timeout #(
        .TW             (TW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state == ST_FORWARD),
        .en_i  (state == ST_RUN_WAIT),
        .tc_o  (tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= ST_IDLE;
            outcome            <= OUT_OK;
            overrun            <= 1'b0;
            last_core          <= '0;
            k_q                <= '0;
            op_q               <= '0;
            result_o           <= '0;
            core_sel_o         <= '0;
            core_instruction_o <= '0;
            core_address_o     <= '0;
            core_value_o       <= '0;
            core_start_o       <= '0;
        end else begin
            core_sel_o         <= '0;
            core_instruction_o <= '0;
            core_address_o     <= '0;
            core_value_o       <= '0;
            core_start_o       <= '0;
            if (instr_valid_i && state != ST_IDLE) overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        case (instruction_i)
                            OP_NOP: ;
                            OP_STATUS: begin
                                result_o <= {24'h0, status_o};
                                overrun  <= 1'b0;
                            end
                            OP_WRITE, OP_READ, OP_RUN: begin
                                if (!in_range) begin
                                    outcome <= OUT_ERR_ADDR;
                                end else begin
                                    // Bus outputs load here so they are valid during FORWARD.
                                    op_q               <= instruction_i;
                                    k_q                <= addr_idx[2:0];
                                    last_core          <= addr_idx[2:0];
                                    core_sel_o         <= addr_onehot;
                                    core_instruction_o <= instruction_i;
                                    core_address_o     <= 24'(address_i[CORE_SPAN_LOG2-1:0]);
                                    core_value_o       <= value_i;
                                    core_start_o       <= (instruction_i == OP_RUN) ? addr_onehot : '0;
                                    state              <= ST_FORWARD;
                                end
                            end
                            default: outcome <= OUT_ERR_OPCODE;
                        endcase
                    end
                end
                ST_FORWARD: begin
                    if (op_q == OP_RUN) begin
                        state <= ST_RUN_WAIT;
                    end else if (op_q == OP_WRITE) begin
                        outcome <= OUT_OK;
                        state   <= ST_IDLE;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    result_o <= sel_result;
                    outcome  <= OUT_OK;
                    state    <= ST_IDLE;
                end
                ST_RUN_WAIT: begin
                    if (done_sel) begin
                        result_o <= sel_result;
                        outcome  <= OUT_OK;
                        state    <= ST_IDLE;
                    end else if (tc) begin
                        outcome <= OUT_TIMEOUT;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a schedule-based model.
module tb_core_scheduler;

    localparam int unsigned NUM = 2;
    localparam int unsigned CSL = 4;
    localparam int unsigned TO  = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [7:0]    instruction_i = '0;
    logic [23:0]   address_i = '0;
    logic [31:0]   value_i = '0;
    logic          instr_valid_i = 1'b0;
    logic          instr_ready_o, busy_o;
    logic [NUM-1:0] core_sel_o, core_start_o;
    logic [NUM-1:0] core_done_i = '0;
    logic [7:0]    core_instruction_o;
    logic [23:0]   core_address_o;
    logic [31:0]   core_value_o;
    logic [63:0]   core_result_i = '0;
    logic [31:0]   result_o;
    logic [7:0]    status_o;

    core_scheduler #(
        .NUM_CORES      (NUM),
        .CORE_SPAN_LOG2 (CSL),
        .TIMEOUT_CYCLES (TO),
        .TW             (16)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .instruction_i      (instruction_i),
        .address_i          (address_i),
        .value_i            (value_i),
        .instr_valid_i      (instr_valid_i),
        .instr_ready_o      (instr_ready_o),
        .busy_o             (busy_o),
        .core_sel_o         (core_sel_o),
        .core_instruction_o (core_instruction_o),
        .core_address_o     (core_address_o),
        .core_value_o       (core_value_o),
        .core_start_o       (core_start_o),
        .core_done_i        (core_done_i),
        .core_result_i      (core_result_i),
        .result_o           (result_o),
        .status_o           (status_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- schedule-based reference model ----------------
    int unsigned cyc = 0;          // index of the cycle currently in progress
    int unsigned m_ready_at = 0;   // first cycle in which a new instruction is accepted
    int unsigned m_t = 0;          // acceptance cycle of the pending instruction
    int unsigned m_k = 0;
    int          m_kind = 0;       // 0 none, 1 write, 2 read, 3 run
    bit          model_on = 0;
    logic [NUM-1:0] e_sel, e_start;
    logic [7:0]  e_ins, e_status;
    logic [23:0] e_addr;
    logic [31:0] e_val, e_res;
    logic [3:0]  e_out;
    logic        e_ov;
    logic [2:0]  e_last;

    initial begin
        forever begin
            @(posedge clk_i);
            e_sel = '0; e_start = '0; e_ins = '0; e_addr = '0; e_val = '0;
            if (rst_i) begin
                e_res = '0; e_out = '0; e_ov = 1'b0; e_last = '0;
                m_kind = 0; m_ready_at = cyc + 1; model_on = 1;
            end else if (model_on) begin
                if (cyc >= m_ready_at) begin
                    if (instr_valid_i) begin
                        int unsigned k;
                        k = int'(address_i >> CSL);
                        case (instruction_i)
                            8'h00: ;
                            8'h01, 8'h02, 8'h03: begin
                                if (k >= NUM) e_out = 4'd2;
                                else begin
                                    m_t = cyc; m_k = k; e_last = 3'(k);
                                    e_sel = NUM'(1) << k;
                                    e_ins = instruction_i;
                                    e_addr = 24'(address_i % (1 << CSL));
                                    e_val = value_i;
                                    if (instruction_i == 8'h03) e_start = NUM'(1) << k;
                                    m_kind = int'(instruction_i);
                                    m_ready_at = (m_kind == 1) ? cyc + 2 :
                                                 (m_kind == 2) ? cyc + 3 : 32'hFFFF_FFFF;
                                end
                            end
                            8'h04: begin
                                e_res = {24'h0, e_last, e_ov, e_out};
                                e_ov = 1'b0;
                            end
                            default: e_out = 4'd3;
                        endcase
                    end
                end else begin
                    if (instr_valid_i) e_ov = 1'b1;
                    if (m_kind == 1 && cyc == m_t + 1) begin
                        e_out = 4'd0; m_kind = 0;
                    end else if (m_kind == 2 && cyc == m_t + 2) begin
                        e_res = core_result_i[32*m_k +: 32]; e_out = 4'd0; m_kind = 0;
                    end else if (m_kind == 3 && cyc >= m_t + 2) begin
                        if (core_done_i[m_k]) begin
                            e_res = core_result_i[32*m_k +: 32]; e_out = 4'd0;
                            m_kind = 0; m_ready_at = cyc + 1;
                        end else if (cyc == m_t + 1 + TO) begin
                            e_out = 4'd1; m_kind = 0; m_ready_at = cyc + 1;
                        end
                    end
                end
            end
            cyc++;
            #1;
            if (model_on) begin
                e_status = {e_last, e_ov, e_out};
                chk("ready", 32'(instr_ready_o), 32'(cyc >= m_ready_at));
                chk("busy", 32'(busy_o), 32'(cyc < m_ready_at));
                chk("core_sel", 32'(core_sel_o), 32'(e_sel));
                chk("core_start", 32'(core_start_o), 32'(e_start));
                chk("core_instr", 32'(core_instruction_o), 32'(e_ins));
                chk("core_addr", 32'(core_address_o), 32'(e_addr));
                chk("core_value", core_value_o, e_val);
                chk("result", result_o, e_res);
                chk("status", 32'(status_o), 32'(e_status));
            end
        end
    end

    // ---------------- core-side input driver ----------------
    bit          rand_mode = 0;
    logic [63:0] fr = '0;
    int unsigned fd_c [4];
    logic [NUM-1:0] fd_v [4];

    initial begin
        forever begin
            @(negedge clk_i);
            if (rand_mode) begin
                for (int b = 0; b < NUM; b++) core_done_i[b] = ($urandom_range(0, 7) == 0);
                core_result_i = {$urandom, $urandom};
            end else begin
                core_done_i = '0;
                for (int j = 0; j < 4; j++) if (cyc == fd_c[j]) core_done_i |= fd_v[j];
                core_result_i = fr;
            end
        end
    end

    task automatic clear_fd();
        for (int j = 0; j < 4; j++) begin fd_c[j] = 32'hFFFF_FFFF; fd_v[j] = '0; end
    endtask

    task automatic adv();
        @(posedge clk_i); #2;
    endtask

    task automatic issue(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
        instruction_i = op; address_i = a; value_i = v; instr_valid_i = 1'b1;
        @(posedge clk_i); #2;
        instr_valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready_o && n < 60) begin adv(); n++; end
        if (!instr_ready_o) begin
            checks++; failures++;
            $display("FAIL wait_ready actual=busy required=ready within 60 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t, starts;
        clear_fd();
        #2;
        repeat (3) adv();
        rst_i = 1'b0;
        adv();
        chk("lit_rst_ready", 32'(instr_ready_o), 32'd1);
        chk("lit_rst_status", 32'(status_o), 32'h0);
        chk("lit_rst_result", result_o, 32'h0);

        // WRITE to core 1, offset 3
        issue(8'h01, 24'h000013, 32'hDEADBEEF);
        chk("lit_wr_sel", 32'(core_sel_o), 32'h2);
        chk("lit_wr_addr", 32'(core_address_o), 32'h3);
        chk("lit_wr_value", core_value_o, 32'hDEADBEEF);
        chk("lit_wr_core", 32'(status_o[7:5]), 32'd1);
        adv();
        chk("lit_wr_outcome", 32'(status_o[3:0]), 32'd0);
        chk("lit_wr_ready", 32'(instr_ready_o), 32'd1);

        // READ from core 0
        fr = {32'h0BADF00D, 32'h12345678};
        issue(8'h02, 24'h000002, 32'h0);
        chk("lit_rd_busy1", 32'(instr_ready_o), 32'd0);
        adv();
        chk("lit_rd_busy2", 32'(instr_ready_o), 32'd0);
        adv();
        chk("lit_rd_result", result_o, 32'h12345678);

        // RUN core 1, done 5 cycles after start; stray done in FORWARD and from core 0
        t = cyc;
        fd_c[0] = t + 1; fd_v[0] = 2'b10;
        fd_c[1] = t + 3; fd_v[1] = 2'b01;
        fd_c[2] = t + 6; fd_v[2] = 2'b10;
        fr = {32'h00000007, 32'h55555555};
        issue(8'h03, 24'h000010, 32'h0);
        starts = 32'(core_start_o[1]);
        for (int i = 0; i < 6; i++) begin adv(); starts += 32'(core_start_o[1]); end
        chk("lit_run_starts", starts, 32'd1);
        chk("lit_run_result", result_o, 32'h7);
        chk("lit_run_outcome", 32'(status_o[3:0]), 32'd0);
        clear_fd();

        // RUN core 0 without done: timeout after 8 wait cycles
        issue(8'h03, 24'h000000, 32'h0);
        repeat (8) adv();
        chk("lit_to_busy", 32'(instr_ready_o), 32'd0);
        adv();
        chk("lit_to_outcome", 32'(status_o[3:0]), 32'd1);
        chk("lit_to_result", result_o, 32'h7);

        // done exactly on the terminal wait cycle wins
        t = cyc;
        fd_c[0] = t + 9; fd_v[0] = 2'b01;
        fr = {32'h0, 32'hCAFE0001};
        issue(8'h03, 24'h000000, 32'h0);
        repeat (9) adv();
        chk("lit_tc_outcome", 32'(status_o[3:0]), 32'd0);
        chk("lit_tc_result", result_o, 32'hCAFE0001);
        clear_fd();

        // address and opcode errors
        issue(8'h02, 24'h000020, 32'h0);
        chk("lit_erraddr_status", 32'(status_o), 32'h02);
        chk("lit_erraddr_sel", 32'(core_sel_o), 32'h0);
        issue(8'h7F, 24'h000000, 32'h0);
        chk("lit_errop_status", 32'(status_o), 32'h03);

        // overrun during RUN_WAIT, then STATUS read-and-clear
        issue(8'h03, 24'h000010, 32'h0);
        adv(); adv();
        instruction_i = 8'h01; instr_valid_i = 1'b1;
        adv();
        instr_valid_i = 1'b0;
        chk("lit_ovr_set", 32'(status_o[4]), 32'd1);
        wait_ready();
        issue(8'h04, 24'h0, 32'h0);
        chk("lit_stat_result", result_o, 32'h31);
        chk("lit_stat_cleared", 32'(status_o), 32'h21);

        // reset in the middle of a RUN
        issue(8'h03, 24'h000010, 32'h0);
        adv();
        rst_i = 1'b1;
        adv();
        rst_i = 1'b0;
        chk("lit_mrst_result", result_o, 32'h0);
        chk("lit_mrst_status", 32'(status_o), 32'h0);
        chk("lit_mrst_ready", 32'(instr_ready_o), 32'd1);
        starts = 0;
        for (int i = 0; i < 12; i++) begin starts += 32'(|core_start_o); adv(); end
        chk("lit_mrst_nostart", starts, 32'd0);

        // randomized traffic
        rand_mode = 1;
        for (int n = 0; n < 400; n++) begin
            logic [7:0]  op;
            logic [23:0] a;
            int unsigned r;
            if ($urandom_range(0, 99) == 0) begin
                rst_i = 1'b1; adv(); rst_i = 1'b0;
            end
            if ($urandom_range(0, 4) != 0) wait_ready();
            repeat ($urandom_range(0, 2)) adv();
            r = $urandom_range(0, 9);
            op = (r < 2) ? 8'h01 : (r < 4) ? 8'h02 : (r < 7) ? 8'h03 :
                 (r == 7) ? 8'h04 : (r == 8) ? 8'h00 : 8'($urandom_range(5, 255));
            if ($urandom_range(0, 4) != 0)
                a = {19'h0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            else
                a = 24'($urandom);
            issue(op, a, $urandom);
        end
        rand_mode = 0;
        wait_ready();
        repeat (3) adv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
